// File: rtl/icap_readback_pkg.sv
// Shared Spartan-6 ICAP definitions: command words, register addresses,
// the byte bit-swap and the type-1 packet header builder.
package icap_readback_pkg;

    typedef logic [15:0] icap_word_t;
    typedef logic [5:0]  cfg_addr_t;

    localparam icap_word_t ICAP_NULL   = 16'hFFFF;
    localparam icap_word_t ICAP_SYNC1  = 16'hAA99;
    localparam icap_word_t ICAP_SYNC2  = 16'h5566;
    localparam icap_word_t ICAP_NOOP   = 16'h2000;
    localparam icap_word_t ICAP_CMD_WR = 16'h30A1;
    localparam icap_word_t ICAP_DESYNC = 16'h000D;
    localparam icap_word_t ICAP_REBOOT = 16'h000E;

    localparam cfg_addr_t REG_STAT     = 6'h08;
    localparam cfg_addr_t REG_GENERAL1 = 6'h13;
    localparam cfg_addr_t REG_GENERAL2 = 6'h14;
    localparam cfg_addr_t REG_MODE     = 6'h18;
    localparam cfg_addr_t REG_BOOTSTS  = 6'h20;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_IDLE, S_DUMMY, S_SYNC1, S_SYNC2, S_NOOP0, S_HDR, S_NOOP1, S_NOOP2,
        S_CE_OFF, S_TURN_R, S_RD_WAIT, S_RD_END, S_TURN_W,
        S_DSY_H, S_DSY_L, S_NOOP3, S_NOOP4, S_DONE
    } rb_state_t;

    // ICAP data pins are bit-reversed within each byte; the mapping is its own inverse.
    function automatic icap_word_t bit_swap(input icap_word_t w);
        icap_word_t r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7 - i];
            r[8 + i] = w[15 - i];
        end
        return r;
    endfunction

    function automatic icap_word_t type1_hdr(input logic [1:0] op, input cfg_addr_t addr,
                                             input logic [4:0] words);
        return {3'b001, op, addr, words};
    endfunction

endpackage

// File: rtl/icap_readback_if.sv
// Read-request handshake plus the ICAP-side pins of the readback block.
interface icap_readback_if;
    import icap_readback_pkg::*;

    logic       rd_req;
    cfg_addr_t  rd_addr;
    logic       rd_busy;
    logic       rd_valid;
    icap_word_t rd_data;
    logic       rd_err;
    logic       icap_ce;
    logic       icap_wr;
    icap_word_t icap_i;
    icap_word_t icap_o;
    logic       icap_busy;

    modport slave (
        input  rd_req, rd_addr, icap_o, icap_busy,
        output rd_busy, rd_valid, rd_data, rd_err, icap_ce, icap_wr, icap_i
    );

    modport master (
        output rd_req, rd_addr, icap_o, icap_busy,
        input  rd_busy, rd_valid, rd_data, rd_err, icap_ce, icap_wr, icap_i
    );

endinterface

// File: rtl/icap_readback.sv
// Reads one configuration register through the ICAP: sync, type-1 read header,
// turnaround, busy-qualified capture, then an unconditional desync.
module icap_readback
    import icap_readback_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    icap_readback_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    // Pins lag the state by one cycle and ICAP inputs are registered, so the
    // first busy sample from the third read cycle is seen at count 4.
    localparam logic [CNT_W-1:0] SAMPLE_C  = CNT_W'(4);

    rb_state_t        state, state_nx;
    cfg_addr_t        addr_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             busy_q;
    icap_word_t       o_q;
    icap_word_t       data_q;
    logic             err_q;

    logic       ce_d, wr_d, capture, expire;
    icap_word_t word_d;

    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        ce_d     = 1'b1;
        wr_d     = 1'b1;
        word_d   = ICAP_NULL;
        capture  = 1'b0;
        expire   = 1'b0;
        unique case (state)
            S_IDLE:   if (bus.rd_req) state_nx = S_DUMMY;
            // WR falls here while CE is still high, so CE and WR never move together.
            S_DUMMY:  begin wr_d = 1'b0;                                   state_nx = S_SYNC1;  end
            S_SYNC1:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_SYNC1; state_nx = S_SYNC2;  end
            S_SYNC2:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_SYNC2; state_nx = S_NOOP0;  end
            S_NOOP0:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_NOOP;  state_nx = S_HDR;    end
            S_HDR:    begin
                ce_d     = 1'b0;
                wr_d     = 1'b0;
                word_d   = type1_hdr(OP_READ, addr_q, 5'd1);
                state_nx = S_NOOP1;
            end
            S_NOOP1:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_NOOP;  state_nx = S_NOOP2;  end
            S_NOOP2:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_NOOP;  state_nx = S_CE_OFF; end
            S_CE_OFF: begin wr_d = 1'b0;                                   state_nx = S_TURN_R; end
            S_TURN_R: state_nx = S_RD_WAIT;
            S_RD_WAIT: begin
                ce_d = 1'b0;
                if (wait_cnt >= SAMPLE_C && !busy_q) begin
                    capture  = 1'b1;
                    state_nx = S_RD_END;
                end else if (wait_cnt >= TIMEOUT_C) begin
                    expire   = 1'b1;
                    state_nx = S_RD_END;
                end
            end
            S_RD_END: state_nx = S_TURN_W;
            S_TURN_W: begin wr_d = 1'b0;                                    state_nx = S_DSY_H; end
            S_DSY_H:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_CMD_WR; state_nx = S_DSY_L; end
            S_DSY_L:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_DESYNC; state_nx = S_NOOP3; end
            S_NOOP3:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_NOOP;   state_nx = S_NOOP4; end
            S_NOOP4:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = ICAP_NOOP;   state_nx = S_DONE;  end
            // CE rises first; WR returns high in IDLE on the following cycle.
            S_DONE:   begin wr_d = 1'b0;                                    state_nx = S_IDLE;  end
            default:  state_nx = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
            o_q      <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            busy_q <= bus.icap_busy;
            o_q    <= bus.icap_o;
            if (state == S_IDLE && bus.rd_req) addr_q <= bus.rd_addr;
            if (state != S_RD_WAIT)            wait_cnt <= '0;
            else if (wait_cnt != TIMEOUT_C)    wait_cnt <= wait_cnt + CNT_W'(1);
            if (capture) begin
                data_q <= bit_swap(o_q);
                err_q  <= 1'b0;
            end else if (expire) begin
                data_q <= ICAP_NULL;
                err_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.icap_ce  <= 1'b1;
            bus.icap_wr  <= 1'b1;
            bus.icap_i   <= ICAP_NULL;
            bus.rd_busy  <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_err   <= 1'b0;
        end else begin
            bus.icap_ce  <= ce_d;
            bus.icap_wr  <= wr_d;
            bus.icap_i   <= bit_swap(word_d);
            bus.rd_busy  <= (state != S_IDLE) && (state != S_DONE);
            bus.rd_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                bus.rd_data <= data_q;
                bus.rd_err  <= err_q;
            end else if (state == S_DUMMY) begin
                bus.rd_err  <= 1'b0;
            end
        end
    end

endmodule
